// File: rtl/mem_arb_pkg.sv
// Shared types and encodings for the instruction/data memory port arbiter.
// Imported by the arbiter top, its grant picker and the testbench.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE,
        BUSY_I,
        BUSY_D,
        BAD_D
    } state_t;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;
    localparam logic [1:0] SZ_BAD  = 2'd3;

    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;

    // Bits needed to hold a streak count of 0..m inclusive.
    function automatic int streak_w(input int m);
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Grant selection between fetch and data requesters.
// Data wins unless it has already taken MAX_D_STREAK grants while fetch waited.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter int MAX_D_STREAK = 4
) (
    input  logic                                    clock,
    input  logic                                    reset,
    input  logic                                    i_req,
    input  logic                                    d_req,
    input  logic                                    idle,
    output logic                                    i_gnt,
    output logic                                    d_gnt,
    output logic [streak_w(MAX_D_STREAK)-1:0]       streak
);

    localparam int SW = streak_w(MAX_D_STREAK);

    logic at_lim;

    assign at_lim = (streak == SW'(MAX_D_STREAK));
    assign d_gnt  = idle && d_req && !(i_req && at_lim);
    assign i_gnt  = idle && i_req && !d_gnt;

    // Count data grants that made fetch wait; any fetch grant or uncontested data grant clears it.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            streak <= '0;
        end else if (d_gnt) begin
            if (!i_req) begin
                streak <= '0;
            end else if (!at_lim) begin
                streak <= streak + SW'(1);
            end
        end else if (i_gnt) begin
            streak <= '0;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single-outstanding arbiter sharing one variable-latency memory port between
// instruction fetch and load/store, with registered port fields and responses.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int MAX_D_STREAK = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [1:0]        d_size,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [1:0]        mem_size,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);

    localparam int SW = streak_w(MAX_D_STREAK);

    state_t        state;
    logic          idle;
    logic          own;
    logic [SW-1:0] streak;

    assign idle = (state == IDLE);
    assign own  = (state == BUSY_D) ? OWN_D : OWN_I;

    mem_arb_pick #(
        .MAX_D_STREAK (MAX_D_STREAK)
    ) u_pick (
        .clock  (clock),
        .reset  (reset),
        .i_req  (i_req),
        .d_req  (d_req),
        .idle   (idle),
        .i_gnt  (i_gnt),
        .d_gnt  (d_gnt),
        .streak (streak)
    );

    // The picker must never let the streak run past its limit.
    a_streak_bound: assert property (
        @(posedge clock) disable iff (!reset) streak <= SW'(MAX_D_STREAK)
    );

    // Transaction FSM: latch on grant, hold the port until ack, pulse the owner's response.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_size  <= SZ_BYTE;
            mem_addr  <= '0;
            mem_wdata <= '0;
            i_rvalid  <= 1'b0;
            i_rdata   <= '0;
            d_rvalid  <= 1'b0;
            d_rdata   <= '0;
            err       <= 1'b0;
        end else begin
            i_rvalid <= 1'b0;
            d_rvalid <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (mem_ack) begin
                        err <= 1'b1;
                    end
                    if (d_gnt) begin
                        if (d_size == SZ_BAD) begin
                            state <= BAD_D;
                            err   <= 1'b1;
                        end else begin
                            state     <= BUSY_D;
                            mem_req   <= 1'b1;
                            mem_we    <= d_we;
                            mem_size  <= d_size;
                            mem_addr  <= d_addr;
                            mem_wdata <= d_wdata;
                        end
                    end else if (i_gnt) begin
                        state     <= BUSY_I;
                        mem_req   <= 1'b1;
                        mem_we    <= 1'b0;
                        mem_size  <= SZ_WORD;
                        mem_addr  <= i_addr;
                        mem_wdata <= '0;
                    end
                end
                BUSY_I, BUSY_D: begin
                    if (mem_ack) begin
                        state   <= IDLE;
                        mem_req <= 1'b0;
                        if (own == OWN_D) begin
                            d_rvalid <= 1'b1;
                            d_rdata  <= mem_we ? '0 : mem_rdata;
                        end else begin
                            i_rvalid <= 1'b1;
                            i_rdata  <= mem_rdata;
                        end
                    end
                end
                BAD_D: begin
                    state    <= IDLE;
                    d_rvalid <= 1'b1;
                    d_rdata  <= '0;
                    if (mem_ack) begin
                        err <= 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed self-checking bench for mem_port_arbiter.
// Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
module tb_mem_port_arbiter;
    import mem_arb_pkg::*;

    logic        clock;
    logic        reset;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_gnt;
    logic        i_rvalid;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [1:0]  d_size;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_gnt;
    logic        d_rvalid;
    logic [31:0] d_rdata;
    logic        mem_req;
    logic        mem_we;
    logic [1:0]  mem_size;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    int n_chk;
    int n_fail;

    mem_port_arbiter #(
        .ADDR_W       (32),
        .DATA_W       (32),
        .MAX_D_STREAK (4)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .i_req     (i_req),
        .i_addr    (i_addr),
        .i_gnt     (i_gnt),
        .i_rvalid  (i_rvalid),
        .i_rdata   (i_rdata),
        .d_req     (d_req),
        .d_we      (d_we),
        .d_size    (d_size),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_gnt     (d_gnt),
        .d_rvalid  (d_rvalid),
        .d_rdata   (d_rdata),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_size  (mem_size),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .err       (err)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic samp();
        @(negedge clock);
    endtask

    int exp_s;
    bit exp_d;

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        reset     = 1'b0;
        i_req     = 1'b0;
        i_addr    = '0;
        d_req     = 1'b0;
        d_we      = 1'b0;
        d_size    = 2'd0;
        d_addr    = '0;
        d_wdata   = '0;
        mem_ack   = 1'b0;
        mem_rdata = '0;

        // reset state
        samp();
        check("rst_mem_req", mem_req, 0);
        check("rst_i_rvalid", i_rvalid, 0);
        check("rst_d_rvalid", d_rvalid, 0);
        check("rst_err", err, 0);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_state", 32'(dut.state), 32'(IDLE));
        #2 reset = 1'b1;

        // solo fetch, ack after 3 busy cycles
        cyc(); i_req = 1'b1; i_addr = 32'h0100_0000;
        samp();
        check("t1_i_gnt", i_gnt, 1);
        check("t1_d_gnt", d_gnt, 0);
        cyc(); i_req = 1'b0;
        samp();
        check("t1_req_c1", mem_req, 1);
        check("t1_addr", mem_addr, 32'h0100_0000);
        check("t1_we", mem_we, 0);
        check("t1_size", mem_size, 2);
        cyc();
        samp();
        check("t1_req_c2", mem_req, 1);
        cyc(); mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
        samp();
        check("t1_req_c3", mem_req, 1);
        check("t1_rv_c3", i_rvalid, 0);
        cyc(); mem_ack = 1'b0; mem_rdata = '0;
        samp();
        check("t1_rv_c4", i_rvalid, 1);
        check("t1_rdata", i_rdata, 32'h0050_0093);
        check("t1_req_c4", mem_req, 0);
        cyc();
        samp();
        check("t1_rv_c5", i_rvalid, 0);
        check("t1_hold", i_rdata, 32'h0050_0093);

        // simultaneous requests: store byte wins, then fetch
        cyc();
        i_req = 1'b1; i_addr = 32'h0100_0004;
        d_req = 1'b1; d_we = 1'b1; d_size = 2'd0;
        d_addr = 32'h0000_2000; d_wdata = 32'h0000_00AB;
        samp();
        check("t2_d_gnt", d_gnt, 1);
        check("t2_i_gnt", i_gnt, 0);
        cyc(); d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
        samp();
        check("t2_we", mem_we, 1);
        check("t2_size", mem_size, 0);
        check("t2_wdata", mem_wdata, 32'h0000_00AB);
        check("t2_busy_i_gnt", i_gnt, 0);
        check("t2_streak1", dut.u_pick.streak, 1);
        cyc(); mem_ack = 1'b0;
        samp();
        check("t2_d_rvalid", d_rvalid, 1);
        check("t2_d_rdata", d_rdata, 0);
        check("t2_i_gnt_rv", i_gnt, 1);
        cyc(); i_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
        samp();
        check("t2_i_addr", mem_addr, 32'h0100_0004);
        check("t2_i_we", mem_we, 0);
        check("t2_streak0", dut.u_pick.streak, 0);
        cyc(); mem_ack = 1'b0;
        samp();
        check("t2_i_rvalid", i_rvalid, 1);
        check("t2_i_rdata", i_rdata, 32'h1111_2222);

        // starvation limit: D,D,D,D,I,D with both requests held
        exp_s = 0;
        for (int k = 0; k < 6; k++) begin
            exp_d = (k != 4);
            exp_s = exp_d ? ((exp_s < 4) ? exp_s + 1 : 4) : 0;
            cyc();
            i_req = 1'b1; i_addr = 32'h0100_0100;
            d_req = 1'b1; d_we = 1'b0; d_size = 2'd2;
            d_addr = 32'h0000_0100 + 32'(4 * k);
            mem_ack = 1'b0;
            samp();
            check($sformatf("t3_d_gnt%0d", k), d_gnt, 32'(exp_d));
            check($sformatf("t3_i_gnt%0d", k), i_gnt, 32'(!exp_d));
            cyc(); mem_ack = 1'b1; mem_rdata = 32'h0000_00A0 + 32'(k);
            samp();
            check($sformatf("t3_streak%0d", k), dut.u_pick.streak, 32'(exp_s));
            check($sformatf("t3_nognt%0d", k), i_gnt | d_gnt, 0);
        end
        cyc(); i_req = 1'b0; d_req = 1'b0; mem_ack = 1'b0;
        samp();
        check("t3_last_rv", d_rvalid, 1);
        check("t3_last_rd", d_rdata, 32'h0000_00A5);
        check("t3_err", err, 0);

        // spurious ack in IDLE
        cyc(); mem_ack = 1'b1; mem_rdata = 32'h5555_5555;
        samp();
        cyc(); mem_ack = 1'b0;
        samp();
        check("t5_err", err, 1);
        check("t5_i_rv", i_rvalid, 0);
        check("t5_d_rv", d_rvalid, 0);
        check("t5_d_rd", d_rdata, 32'h0000_00A5);
        cyc(); d_req = 1'b1; d_we = 1'b0; d_size = 2'd1; d_addr = 32'h40;
        samp();
        check("t5_d_gnt", d_gnt, 1);
        cyc(); d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_BEEF;
        samp();
        check("t5_size", mem_size, 1);
        cyc(); mem_ack = 1'b0;
        samp();
        check("t5_d_rv2", d_rvalid, 1);
        check("t5_d_rd2", d_rdata, 32'h0000_BEEF);

        // reset during a BUSY_D wait
        cyc(); d_req = 1'b1; d_we = 1'b1; d_size = 2'd2; d_wdata = 32'h55;
        samp();
        check("t6_d_gnt", d_gnt, 1);
        cyc(); d_req = 1'b0;
        samp();
        check("t6_busy", mem_req, 1);
        #2 reset = 1'b0;
        #1;
        check("t6_async_req", mem_req, 0);
        check("t6_async_err", err, 0);
        @(posedge clock);
        #2 reset = 1'b1;
        samp();
        check("t6_no_rv", d_rvalid, 0);
        check("t6_state", 32'(dut.state), 32'(IDLE));
        cyc(); i_req = 1'b1; i_addr = 32'h0100_0010;
        samp();
        check("t6_i_gnt", i_gnt, 1);
        cyc(); i_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_0777;
        samp();
        check("t6_addr", mem_addr, 32'h0100_0010);
        cyc(); mem_ack = 1'b0;
        samp();
        check("t6_i_rv", i_rvalid, 1);
        check("t6_i_rd", i_rdata, 32'h0000_0777);
        check("t6_d_rv", d_rvalid, 0);

        // load so d_rdata is nonzero before the illegal request
        cyc(); d_req = 1'b1; d_we = 1'b0; d_size = 2'd2; d_addr = 32'h80;
        samp();
        cyc(); d_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_1234;
        samp();
        cyc(); mem_ack = 1'b0;
        samp();
        check("t4_pre_rd", d_rdata, 32'h0000_1234);

        // illegal size
        cyc(); d_req = 1'b1; d_size = 2'd3; d_addr = 32'hC0;
        samp();
        check("t4_d_gnt", d_gnt, 1);
        cyc(); d_req = 1'b0; i_req = 1'b1; i_addr = 32'h0100_0020;
        samp();
        check("t4_no_mreq", mem_req, 0);
        check("t4_rv_early", d_rvalid, 0);
        check("t4_bad_i_gnt", i_gnt, 0);
        check("t4_err", err, 1);
        cyc();
        samp();
        check("t4_rv", d_rvalid, 1);
        check("t4_rd", d_rdata, 0);
        check("t4_i_gnt", i_gnt, 1);
        cyc(); i_req = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0000_3333;
        samp();
        check("t4_mreq", mem_req, 1);
        check("t4_rv_off", d_rvalid, 0);
        cyc(); mem_ack = 1'b0;
        samp();
        check("t4_i_rv", i_rvalid, 1);
        check("t4_i_rd", i_rdata, 32'h0000_3333);
        check("t4_err_held", err, 1);
        #2 reset = 1'b0;
        #1;
        check("t4_err_clr", err, 0);
        #3 reset = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbitrates one single-ported, variable-latency memory between the pipeline's instruction-fetch requester (I) and load/store requester (D). It accepts one request at a time, drives the shared memory port with registered fields and returns a registered response to the requester that owns the transaction. Data accesses have priority, and a streak limit keeps fetch from starving. It sits between the fetch/memory stages and the unified memory model.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- MAX_D_STREAK, 4, maximum consecutive D grants while I is waiting (≥1)

- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- i_req  in  1  fetch request; held with i_addr stable until i_gnt
- i_addr  in  ADDR_W  fetch address (word read)
- i_gnt  out  1  fetch request accepted this cycle (combinational)
- i_rvalid  out  1  one-cycle fetch completion pulse (registered)
- i_rdata  out  DATA_W  fetch data, valid with i_rvalid
- d_req  in  1  data request; held with its fields stable until d_gnt
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  0 = byte, 1 = half, 2 = word, 3 = illegal
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  store data
- d_gnt  out  1  data request accepted this cycle (combinational)
- d_rvalid  out  1  one-cycle completion pulse for loads and stores (registered)
- d_rdata  out  DATA_W  load data; 0 for stores and illegal requests
- mem_req  out  1  memory transaction active (registered)
- mem_we, mem_size, mem_addr, mem_wdata  out  1/2/ADDR_W/DATA_W  transaction fields (registered); I transactions use we=0, size=2
- mem_ack  in  1  memory completes the transaction; mem_rdata is valid in the same cycle
- mem_rdata  in  DATA_W  read data
- err  out  1  sticky protocol/illegal-size flag; cleared only by reset

## Operation
- States: IDLE, BUSY_I, BUSY_D, BAD_D.
- IDLE: the arbiter picks at most one requester and asserts its gnt in the same cycle. At the clock edge it latches the request fields.
  - Only one requester active: grant it.
  - Both active: grant D unless streak == MAX_D_STREAK, in which case grant I.
- Grant transitions:
  - D grant with d_size == 3: go to BAD_D. The request is not forwarded to memory and err is set.
  - Other D grant: go to BUSY_D.
  - I grant: go to BUSY_I.
- BUSY_x: mem_req = 1 with the latched fields held stable. On mem_ack, go to IDLE and capture mem_rdata into x_rdata. d_rdata is forced to 0 for stores.
- BAD_D: unconditionally return to IDLE after one cycle. d_rvalid = 1 and d_rdata = 0 in the next cycle.
- x_rvalid pulses for exactly one cycle, in the cycle after the completing event.
- No gnt outputs are asserted outside IDLE.
- streak counter, width clog2(MAX_D_STREAK+1):
  - Increments on a D grant while i_req = 1, saturating at MAX_D_STREAK.
  - Cleared on an I grant, or on a D grant while i_req = 0.
- mem_ack in IDLE or BAD_D: ignored, and err is set.
- A requester dropping req before gnt is legal; nothing is granted for it.

## Timing
- Reset values: all outputs 0, state IDLE, streak 0, err 0.
- Reset assertion takes effect asynchronously: mem_req drops immediately and any in-flight transaction is discarded with no rvalid. Reset deassertion is synchronised externally.
- Minimum latency: gnt in cycle 0, mem_req from cycle 1, mem_ack in cycle 1, rvalid in cycle 2.
- One outstanding transaction; peak throughput is one transaction per 2 cycles.
- IDLE is re-entered at the edge that samples mem_ack. A new gnt can therefore occur in the same cycle as the previous transaction's rvalid.
- mem_req stays high across arbitrary wait states until mem_ack. Fields do not change while mem_req = 1.
- i_rdata and d_rdata hold their last value between pulses.

## Structure
- Shared package mem_arb_pkg holds:
  - state enum (IDLE, BUSY_I, BUSY_D, BAD_D)
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_BAD
  - owner constants OWN_I, OWN_D
- One sub-module, mem_arb_pick, holds the combinational grant selection plus the streak counter register. It takes i_req, d_req, an idle flag and MAX_D_STREAK, and produces i_gnt, d_gnt and the streak value.
- The FSM, field registers and response registers live in the top module.

## Test plan
- Solo fetch: i_req, i_addr=0x01000000, mem_ack 3 cycles after mem_req, mem_rdata=0x00500093.
  - Required: i_gnt in cycle 0; mem_req in cycles 1–3 with addr 0x01000000, we=0, size=2; i_rvalid in cycle 4 with i_rdata=0x00500093.
- Simultaneous requests: I and D raised together, d_we=1, size=0, wdata=0xAB, mem_ack immediate.
  - Required: d_gnt first; mem_we=1, mem_size=0; d_rvalid with d_rdata=0.
  - Then i_gnt in the same cycle as d_rvalid.
- Starvation limit, MAX_D_STREAK=4: d_req held continuously and i_req held high.
  - Required: grant order D,D,D,D,I,D…; streak reads 0 after the I grant.
- Illegal size: d_size=3.
  - Required: d_gnt, mem_req stays 0, d_rvalid next cycle with d_rdata=0, err=1 held until reset.
- Spurious ack: mem_ack pulsed in IDLE.
  - Required: no rvalid on either port, err=1, subsequent arbitration unaffected.
- Reset mid-operation: reset driven low during BUSY_D wait.
  - Required: mem_req=0 immediately, without a clock edge.
  - After release: no d_rvalid, state IDLE, a new fetch completes normally.
